// File: rtl/icache_top.sv
// Direct-mapped instruction cache: single-cycle hit path, line refill from a
// beat-oriented memory port, with flush (response cancel) and invalidate-all.
module icache_top #(
  parameter int ADDR       = 32,
  parameter int INST       = 32,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            ic_req,
  input  logic [ADDR-1:0] ic_addr,
  output logic            ic_ready,
  input  logic            ic_flush,
  input  logic            ic_inv,
  output logic            ic_valid,
  output logic [INST-1:0] ic_inst,
  output logic [ADDR-1:0] ic_raddr,
  output logic            mem_req,
  output logic [ADDR-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic            mem_rvalid,
  input  logic [INST-1:0] mem_rdata
);

  localparam int LSB   = 2;
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR - LSB - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL, RESP} state_t;

  state_t state, state_nx;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [INST-1:0]  data_mem [SETS][LINE_WORDS];

  logic [ADDR-1:0]  lat_addr;
  logic [OFF_W-1:0] beat_cnt;
  logic             flush_pend;
  logic             inv_pend;

  logic [OFF_W-1:0] req_off, lat_off;
  logic [IDX_W-1:0] req_idx, lat_idx;
  logic [TAG_W-1:0] req_tag, lat_tag;
  logic             accept, hit, last_beat;

  assign req_off = ic_addr[LSB +: OFF_W];
  assign req_idx = ic_addr[LSB+OFF_W +: IDX_W];
  assign req_tag = ic_addr[ADDR-1 -: TAG_W];
  assign lat_off = lat_addr[LSB +: OFF_W];
  assign lat_idx = lat_addr[LSB+OFF_W +: IDX_W];
  assign lat_tag = lat_addr[ADDR-1 -: TAG_W];

  assign ic_ready  = (state == IDLE) && !ic_inv && !inv_pend;
  assign accept    = ic_req && ic_ready;
  assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign last_beat = (state == REFILL) && mem_rvalid &&
                     (beat_cnt == OFF_W'(LINE_WORDS - 1));

  assign mem_req  = (state == MISS_REQ);
  assign mem_addr = {lat_addr[ADDR-1:LSB+OFF_W], {(LSB+OFF_W){1'b0}}};

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept && !hit) state_nx = MISS_REQ;
      MISS_REQ: if (mem_ack)        state_nx = REFILL;
      REFILL:   if (last_beat)      state_nx = RESP;
      RESP:                         state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      valid      <= '0;
      lat_addr   <= '0;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
      inv_pend   <= 1'b0;
      ic_valid   <= 1'b0;
      ic_inst    <= '0;
      ic_raddr   <= '0;
    end else begin
      ic_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ic_inv) valid <= '0;
          if (accept) begin
            if (hit) begin
              ic_valid <= !ic_flush;
              ic_inst  <= data_mem[req_idx][req_off];
              ic_raddr <= ic_addr;
            end else begin
              lat_addr <= ic_addr;
              beat_cnt <= '0;
            end
          end
        end
        MISS_REQ: begin
          if (ic_flush) flush_pend <= 1'b1;
          if (ic_inv)   inv_pend   <= 1'b1;
        end
        REFILL: begin
          if (ic_flush) flush_pend <= 1'b1;
          if (ic_inv)   inv_pend   <= 1'b1;
          if (mem_rvalid) beat_cnt <= beat_cnt + OFF_W'(1);
          // Response is registered on the last beat so it appears in RESP;
          // the requested word may be the beat arriving this very cycle.
          if (last_beat) begin
            valid[lat_idx] <= 1'b1;
            ic_valid       <= !(flush_pend || ic_flush);
            ic_inst        <= (lat_off == beat_cnt) ? mem_rdata
                                                    : data_mem[lat_idx][lat_off];
            ic_raddr       <= lat_addr;
          end
        end
        RESP: begin
          if (inv_pend || ic_inv) valid <= '0;
          inv_pend   <= 1'b0;
          flush_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == REFILL && mem_rvalid) data_mem[lat_idx][beat_cnt] <= mem_rdata;
    if (last_beat)                     tag_mem[lat_idx] <= lat_tag;
  end

endmodule

// File: tb/tb_icache_top.sv
// Directed self-checking bench for icache_top: cold miss, hits, conflict,
// flush, invalidate and reset-during-refill scenarios.
module tb_icache_top;

  logic        clk = 1'b0;
  logic        reset_;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ready;
  logic        ic_flush;
  logic        ic_inv;
  logic        ic_valid;
  logic [31:0] ic_inst;
  logic [31:0] ic_raddr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  icache_top #(
    .ADDR(32), .INST(32), .SETS(16), .LINE_WORDS(4)
  ) dut (
    .clk(clk), .reset_(reset_),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready),
    .ic_flush(ic_flush), .ic_inv(ic_inv),
    .ic_valid(ic_valid), .ic_inst(ic_inst), .ic_raddr(ic_raddr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Called one cycle after a miss was accepted (state MISS_REQ). Returns with
  // the DUT in RESP, or early in REFILL after stop_after beats.
  task automatic serve_miss(input logic [31:0] maddr, input logic [31:0] base,
                            input int ack_dly, input int flush_at,
                            input int inv_at, input int stop_after);
    chk("mem_req", mem_req, 1);
    chk("mem_addr", mem_addr, maddr);
    for (int i = 0; i < ack_dly; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_0000;
      cyc;
    end
    mem_rvalid = 1'b0;
    mem_ack    = 1'b1;
    cyc;
    mem_ack = 1'b0;
    chk("mem_req_drop", mem_req, 0);
    for (int b = 0; b < 4; b++) begin
      if (b == stop_after) return;
      mem_rvalid = 1'b1;
      mem_rdata  = base + 32'(b);
      ic_flush   = (b == flush_at);
      ic_inv     = (b == inv_at);
      cyc;
      mem_rvalid = 1'b0;
      ic_flush   = 1'b0;
      ic_inv     = 1'b0;
      mem_rdata  = 32'hBAD0_0000;
      if (b == 1) begin
        chk("refill_ready", ic_ready, 0);
        cyc;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

  initial begin
    reset_ = 1'b0; ic_req = 1'b0; ic_addr = '0; ic_flush = 1'b0; ic_inv = 1'b0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_valid", ic_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_inst", ic_inst, 0);
    chk("rst_raddr", ic_raddr, 0);
    cyc;
    reset_ = 1'b1;
    cyc;
    chk("rst_ready", ic_ready, 1);

    // Cold miss at 0x1008
    ic_req = 1'b1; ic_addr = 32'h0000_1008;
    cyc;
    ic_req = 1'b0;
    chk("miss_no_resp", ic_valid, 0);
    chk("miss_ready", ic_ready, 0);
    serve_miss(32'h0000_1000, 32'hA0, 2, -1, -1, 4);
    chk("cold_valid", ic_valid, 1);
    chk("cold_inst", ic_inst, 32'hA2);
    chk("cold_raddr", ic_raddr, 32'h0000_1008);
    chk("resp_ready", ic_ready, 0);
    cyc;
    chk("resp_one_cycle", ic_valid, 0);
    chk("idle_ready", ic_ready, 1);

    // Back-to-back hits
    ic_req = 1'b1; ic_addr = 32'h0000_1000;
    cyc;
    ic_addr = 32'h0000_1004;
    chk("hit0_valid", ic_valid, 1);
    chk("hit0_inst", ic_inst, 32'hA0);
    chk("hit0_raddr", ic_raddr, 32'h0000_1000);
    chk("hit0_memreq", mem_req, 0);
    cyc;
    ic_addr = 32'h0000_100C;
    chk("hit1_valid", ic_valid, 1);
    chk("hit1_inst", ic_inst, 32'hA1);
    chk("hit1_memreq", mem_req, 0);
    cyc;
    ic_req = 1'b0;
    chk("hit2_valid", ic_valid, 1);
    chk("hit2_inst", ic_inst, 32'hA3);
    chk("hit2_raddr", ic_raddr, 32'h0000_100C);
    chk("hit2_memreq", mem_req, 0);
    cyc;
    chk("hit_end", ic_valid, 0);

    // Conflict on index 0
    ic_req = 1'b1; ic_addr = 32'h0000_2008;
    cyc;
    ic_req = 1'b0;
    chk("conf_no_resp", ic_valid, 0);
    serve_miss(32'h0000_2000, 32'hB0, 0, -1, -1, 4);
    chk("conf_inst", ic_inst, 32'hB2);
    cyc;
    ic_req = 1'b1; ic_addr = 32'h0000_1000;
    cyc;
    ic_req = 1'b0;
    chk("evict_no_resp", ic_valid, 0);
    serve_miss(32'h0000_1000, 32'hC0, 1, -1, -1, 4);
    chk("evict_valid", ic_valid, 1);
    chk("evict_inst", ic_inst, 32'hC0);
    chk("evict_raddr", ic_raddr, 32'h0000_1000);
    cyc;

    // Flush during refill beat 1
    ic_req = 1'b1; ic_addr = 32'h0000_2008;
    cyc;
    ic_req = 1'b0;
    serve_miss(32'h0000_2000, 32'hD0, 0, 1, -1, 4);
    chk("flush_no_resp", ic_valid, 0);
    cyc;
    chk("flush_ready", ic_ready, 1);
    ic_req = 1'b1; ic_addr = 32'h0000_2008;
    cyc;
    ic_req = 1'b0;
    chk("flush_hit_valid", ic_valid, 1);
    chk("flush_hit_inst", ic_inst, 32'hD2);
    chk("flush_hit_memreq", mem_req, 0);

    // Flush alongside a hit suppresses that response
    ic_req = 1'b1; ic_addr = 32'h0000_2004; ic_flush = 1'b1;
    cyc;
    ic_req = 1'b0; ic_flush = 1'b0;
    chk("hit_flush_valid", ic_valid, 0);
    chk("hit_flush_memreq", mem_req, 0);

    // Invalidate during refill
    ic_req = 1'b1; ic_addr = 32'h0000_3010;
    cyc;
    ic_req = 1'b0;
    serve_miss(32'h0000_3010, 32'hE0, 0, -1, 2, 4);
    chk("inv_resp_valid", ic_valid, 1);
    chk("inv_resp_inst", ic_inst, 32'hE0);
    chk("inv_resp_ready", ic_ready, 0);
    cyc;
    chk("inv_ready_after", ic_ready, 1);
    ic_req = 1'b1; ic_addr = 32'h0000_3010;
    cyc;
    ic_req = 1'b0;
    chk("inv_miss_valid", ic_valid, 0);
    serve_miss(32'h0000_3010, 32'hF0, 0, -1, -1, 4);
    chk("inv_refill_inst", ic_inst, 32'hF0);
    cyc;

    // Invalidate in IDLE blocks acceptance and clears the line
    ic_req = 1'b1; ic_addr = 32'h0000_3014; ic_inv = 1'b1;
    #1;
    chk("idle_inv_ready", ic_ready, 0);
    cyc;
    ic_inv = 1'b0;
    chk("idle_inv_no_hit", ic_valid, 0);
    cyc;
    ic_req = 1'b0;
    chk("idle_inv_miss", ic_valid, 0);
    serve_miss(32'h0000_3010, 32'h50, 0, -1, -1, 4);
    chk("idle_inv_inst", ic_inst, 32'h51);
    cyc;

    // Reset after two beats
    ic_req = 1'b1; ic_addr = 32'h0000_4008;
    cyc;
    ic_req = 1'b0;
    serve_miss(32'h0000_4000, 32'h60, 0, -1, -1, 2);
    reset_ = 1'b0;
    #1;
    chk("mid_rst_memreq", mem_req, 0);
    chk("mid_rst_valid", ic_valid, 0);
    chk("mid_rst_ready", ic_ready, 1);
    cyc;
    reset_ = 1'b1;
    cyc;
    ic_req = 1'b1; ic_addr = 32'h0000_4008;
    cyc;
    ic_req = 1'b0;
    chk("post_rst_miss", ic_valid, 0);
    serve_miss(32'h0000_4000, 32'h70, 0, -1, -1, 4);
    chk("post_rst_valid", ic_valid, 1);
    chk("post_rst_inst", ic_inst, 32'h72);
    chk("post_rst_raddr", ic_raddr, 32'h0000_4008);
    cyc;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/icache_top.md
ICACHE_TOP -- requirements
Module: icache_top

Interface
REQ-001 The block SHALL have parameter ADDR, default 32, meaning fetch address width in bits.
REQ-002 The block SHALL have parameter INST, default 32, meaning instruction word width in bits.
REQ-003 The block SHALL have parameter SETS, default 16, meaning number of direct-mapped lines (power of 2).
REQ-004 The block SHALL have parameter LINE_WORDS, default 4, meaning instructions per line (power of 2).
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low. Ports: clk in 1 clock; reset_ in 1 async active-low reset.
REQ-006 The block SHALL have these fetch-side ports: ic_req in 1 fetch request; ic_addr in ADDR request address; ic_ready out 1 request accepted when high; ic_flush in 1 cancel in-flight response; ic_inv in 1 invalidate all lines.
REQ-007 The block SHALL have these fetch-side response ports: ic_valid out 1 response valid; ic_inst out INST instruction; ic_raddr out ADDR address of the returned instruction.
REQ-008 The block SHALL have these memory-side ports: mem_req out 1 line read request; mem_addr out ADDR line-aligned address; mem_ack in 1 request accepted; mem_rvalid in 1 beat valid; mem_rdata in INST beat data.

Function
REQ-009 The block SHALL decode addresses as follows: bits [1:0] ignored; word offset = next log2(LINE_WORDS) bits; index = next log2(SETS) bits; tag = remaining upper bits. With defaults: offset [3:2], index [7:4], tag [31:8].
REQ-010 The block SHALL use FSM states IDLE, MISS_REQ, REFILL and RESP; reset state is IDLE.
REQ-011 The block SHALL drive ic_ready = (state==IDLE) && !ic_inv && !inv_pend; a request is accepted when ic_req && ic_ready.
REQ-012 On a hit at acceptance (valid[index] and tag match, evaluated against current arrays), the block SHALL assert ic_valid in the next cycle with ic_inst = data[index][offset] and ic_raddr = the accepted address. Back-to-back hits SHALL sustain one response per cycle.
REQ-013 On a miss at acceptance, the block SHALL latch the address, go to MISS_REQ and assert no response that cycle.
REQ-014 In MISS_REQ the block SHALL hold mem_req=1 and mem_addr = latched address with offset and bits [1:0] zeroed, until mem_ack; on mem_ack it SHALL go to REFILL and deassert mem_req in the next cycle.
REQ-015 In REFILL the block SHALL write each mem_rvalid beat into word beat_cnt (0..LINE_WORDS-1, in order) of the line; on the last beat it SHALL set the tag and valid bit and go to RESP; cycles without mem_rvalid SHALL hold the count.
REQ-016 In RESP the block SHALL assert ic_valid for one cycle with the refilled word at the latched offset and ic_raddr = latched address, then return to IDLE.
REQ-017 ic_flush SHALL suppress any ic_valid due in the following cycle (hit response or RESP). If asserted in MISS_REQ or REFILL, the refill SHALL still complete and the line SHALL be installed, but RESP SHALL produce ic_valid=0. A flag SHALL hold the cancellation until RESP.
REQ-018 ic_inv in IDLE SHALL clear all valid bits at the next edge. In any other state it SHALL set inv_pend, and the clear SHALL be applied on the cycle of return to IDLE, after the refilled line is installed (that line is also invalidated).
REQ-019 A request SHALL not be accepted while ic_inv or inv_pend is high.
REQ-020 ic_ready SHALL be 0 in MISS_REQ, REFILL and RESP; ic_req during those states SHALL be ignored, and fetch holds the request.
REQ-021 mem_rvalid outside REFILL and mem_ack outside MISS_REQ SHALL be ignored.

Reset
REQ-022 On reset_ low the block SHALL asynchronously set state IDLE, all valid bits 0, beat_cnt 0, flags 0, ic_valid 0, ic_inst 0, ic_raddr 0, mem_req 0, mem_addr 0; ic_ready SHALL be 1 after release.
REQ-023 Reset mid-refill SHALL abandon the refill without installing the line; data array contents need no reset.

Verification
REQ-024 Cold miss: req addr 0x0000_1008, ack after 2 cycles, beats 0xA0..0xA3 -> mem_addr 0x0000_1000, ic_valid one cycle after last beat, ic_inst 0xA2, ic_raddr 0x0000_1008.
REQ-025 Hits: after REQ-024, reqs 0x1000, 0x1004, 0x100C on consecutive cycles -> ic_valid on 3 consecutive cycles with 0xA0, 0xA1, 0xA3; mem_req stays 0.
REQ-026 Conflict: req 0x0000_2008 (same index 0, different tag) -> miss refill at 0x2000; a following req 0x1000 misses again.
REQ-027 Flush during refill: ic_flush pulsed in REFILL beat 1 -> all 4 beats consumed, no ic_valid, and a subsequent req 0x2008 hits at 1-cycle latency.
REQ-028 Invalidate: ic_inv during REFILL -> ic_ready held 0 until after RESP; next req to the refilled address misses.
REQ-029 Reset mid-refill after 2 beats -> mem_req 0, ic_valid 0; req to the same address after reset misses and refills.
